// File: rtl/dev_bridge.sv
// CPU-side initiator for the peripheral window: decodes one load/store to Timer0,
// Timer1 or the external-interrupt register, runs a single device cycle, returns a response.
module dev_bridge #(
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
  parameter logic [31:0] INT_BASE = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  output logic        cpu_ready,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [29:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic        tc0_we,
  output logic        tc1_we,
  input  logic [31:0] tc0_rdata,
  input  logic [31:0] tc1_rdata,
  input  logic        tc0_irq,
  input  logic        tc1_irq,
  input  logic        ext_irq,
  output logic [5:0]  hwint
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_TC0, SEL_TC1, SEL_INT} sel_t;

  state_t      state_reg, state_next;
  sel_t        sel_reg, sel_next;
  logic        we_reg;
  logic        ext_irq_q;
  logic        ext_pend;
  logic [1:0]  tc_hit;
  logic        accept;
  logic        ext_rise;
  logic        ext_clear;
  logic [31:0] read_mux;

  // Each timer owns three words starting at its base.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tc_dec
      localparam logic [31:0] BASE = (gi == 0) ? TC0_BASE : TC1_BASE;
      assign tc_hit[gi] = (cpu_addr >= BASE) && (cpu_addr <= BASE + 32'd11);
    end
  endgenerate

  always_comb begin
    sel_next = SEL_NONE;
    if (cpu_addr[1:0] == 2'b00) begin
      if (tc_hit[0])                 sel_next = SEL_TC0;
      else if (tc_hit[1])            sel_next = SEL_TC1;
      else if (cpu_addr == INT_BASE) sel_next = SEL_INT;
    end
  end

  assign cpu_ready = (state_reg == IDLE) & ~reset;
  assign accept    = cpu_req & cpu_ready;
  assign ext_rise  = ext_irq & ~ext_irq_q;
  assign ext_clear = (state_reg == ACCESS) && (sel_reg == SEL_INT) && we_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_mux = 32'd0;
    case (sel_reg)
      SEL_TC0: read_mux = tc0_rdata;
      SEL_TC1: read_mux = tc1_rdata;
      SEL_INT: read_mux = {31'd0, ext_pend};
      default: read_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_reg    <= SEL_NONE;
      we_reg     <= 1'b0;
      dev_addr   <= 30'd0;
      dev_wdata  <= 32'd0;
      tc0_we     <= 1'b0;
      tc1_we     <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= 32'd0;
      cpu_err    <= 1'b0;
      ext_irq_q  <= 1'b0;
      ext_pend   <= 1'b0;
      hwint      <= 6'd0;
    end else begin
      tc0_we     <= 1'b0;
      tc1_we     <= 1'b0;
      if (accept) begin
        sel_reg   <= sel_next;
        we_reg    <= cpu_we;
        dev_addr  <= cpu_addr[31:2];
        dev_wdata <= cpu_wdata;
        tc0_we    <= cpu_we && (sel_next == SEL_TC0);
        tc1_we    <= cpu_we && (sel_next == SEL_TC1);
      end
      cpu_rvalid <= (state_reg == ACCESS);
      if (state_reg == ACCESS) begin
        cpu_rdata <= we_reg ? 32'd0 : read_mux;
        cpu_err   <= (sel_reg == SEL_NONE);
      end
      // A new edge outranks a clear landing in the same cycle.
      ext_irq_q <= ext_irq;
      if (ext_rise)       ext_pend <= 1'b1;
      else if (ext_clear) ext_pend <= 1'b0;
      hwint <= {3'b000, ext_pend, tc1_irq, tc0_irq};
    end
  end

endmodule

// File: tb/tb_dev_bridge.sv
// Scoreboarded bench for dev_bridge: expected responses are queued when a
// request is issued and popped when the response strobe appears.
module tb_dev_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_ready;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [29:0] dev_addr;
  logic [31:0] dev_wdata;
  logic        tc0_we, tc1_we;
  logic [31:0] tc0_rdata = 32'd0;
  logic [31:0] tc1_rdata = 32'd0;
  logic        tc0_irq = 1'b0;
  logic        tc1_irq = 1'b0;
  logic        ext_irq = 1'b0;
  logic [5:0]  hwint;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  dev_bridge dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .tc0_we(tc0_we), .tc1_we(tc1_we),
    .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata),
    .tc0_irq(tc0_irq), .tc1_irq(tc1_irq), .ext_irq(ext_irq),
    .hwint(hwint)
  );

  always #5 clk = ~clk;

  // Drives one request and reports what the bus showed; rdata/err stay X on timeout.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic irq_in_access,
                            output logic [31:0] rdata, output logic err,
                            output int n0, output int n1,
                            output logic [29:0] daddr, output logic [31:0] dwdata,
                            output int lat);
    int cycles = 0;
    logic rv = 1'b0;
    rdata = 'x; err = 1'bx; n0 = 0; n1 = 0; daddr = 'x; dwdata = 'x; lat = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    while (!cpu_ready && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
    cycles = 0;
    @(negedge clk);
    cpu_req = 1'b0;
    if (irq_in_access) ext_irq = 1'b1;
    while (!rv && cycles < 8) begin
      cycles++;
      n0 += int'(tc0_we);
      n1 += int'(tc1_we);
      if (tc0_we || tc1_we) begin
        daddr = dev_addr; dwdata = dev_wdata;
      end
      if (cpu_rvalid) begin
        rv = 1'b1; rdata = cpu_rdata; err = cpu_err; lat = cycles;
      end else begin
        @(negedge clk);
      end
    end
    $display("txn we=%0d addr=%h wdata=%h -> rdata=%h err=%b strobes=%0d/%0d lat=%0d",
             we, addr, wdata, rdata, err, n0, n1, lat);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (cpu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b exp 0", cpu_ready); end
    vectors++;
    if (hwint !== 6'd0) begin miscompares++; $display("FAIL reset_hwint got %b exp 000000", hwint); end
    vectors++;
    if ({cpu_rvalid, cpu_err, tc0_we, tc1_we} !== 4'b0) begin
      miscompares++; $display("FAIL reset_ctrl got %b exp 0000", {cpu_rvalid, cpu_err, tc0_we, tc1_we});
    end
    vectors++;
    if ({dev_addr, dev_wdata, cpu_rdata} !== 94'd0) begin
      miscompares++; $display("FAIL reset_data got %h/%h/%h exp 0", dev_addr, dev_wdata, cpu_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset got %b exp 1", cpu_ready); end
  endtask

  task automatic test_store_tc0();
    logic [31:0] rd; logic er; int n0, n1, lat; logic [29:0] da; logic [31:0] dw; exp_t e;
    sb.push_back('{rdata: 32'd0, err: 1'b0});
    run_access(1'b1, 32'h0000_7F00, 32'h0000_0009, 1'b0, rd, er, n0, n1, da, dw, lat);
    e = sb.pop_front();
    vectors++;
    if ({rd, er} !== {e.rdata, e.err}) begin miscompares++; $display("FAIL store_tc0_resp got %h/%b exp %h/%b", rd, er, e.rdata, e.err); end
    vectors++;
    if (n0 !== 1 || n1 !== 0) begin miscompares++; $display("FAIL store_tc0_strobes got %0d/%0d exp 1/0", n0, n1); end
    vectors++;
    if (da !== 30'h1FC0) begin miscompares++; $display("FAIL store_tc0_addr got %h exp 1fc0", da); end
    vectors++;
    if (dw !== 32'd9) begin miscompares++; $display("FAIL store_tc0_wdata got %h exp 9", dw); end
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL store_tc0_latency got %0d exp 2", lat); end
  endtask

  task automatic test_load_tc1();
    logic [31:0] rd; logic er; int n0, n1, lat; logic [29:0] da; logic [31:0] dw; exp_t e;
    tc0_rdata = 32'hDEAD_BEEF;
    tc1_rdata = 32'h0000_0042;
    sb.push_back('{rdata: 32'h42, err: 1'b0});
    run_access(1'b0, 32'h0000_7F18, 32'h0, 1'b0, rd, er, n0, n1, da, dw, lat);
    e = sb.pop_front();
    vectors++;
    if ({rd, er} !== {e.rdata, e.err}) begin miscompares++; $display("FAIL load_tc1_resp got %h/%b exp %h/%b", rd, er, e.rdata, e.err); end
    vectors++;
    if (n0 + n1 !== 0) begin miscompares++; $display("FAIL load_tc1_strobes got %0d exp 0", n0 + n1); end
  endtask

  task automatic test_decode_errors();
    logic [31:0] addrs [3] = '{32'h0000_7F0C, 32'h0000_7F01, 32'h0000_3000};
    logic [31:0] rd; logic er; int n0, n1, lat; logic [29:0] da; logic [31:0] dw; exp_t e;
    tc0_rdata = 32'h1111_1111;
    tc1_rdata = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{rdata: 32'd0, err: 1'b1});
      run_access(1'b0, addrs[i], 32'h0, 1'b0, rd, er, n0, n1, da, dw, lat);
      e = sb.pop_front();
      vectors++;
      if ({rd, er} !== {e.rdata, e.err}) begin miscompares++; $display("FAIL decode_err_load[%h] got %h/%b exp %h/%b", addrs[i], rd, er, e.rdata, e.err); end
      sb.push_back('{rdata: 32'd0, err: 1'b1});
      run_access(1'b1, addrs[i], 32'h5A5A_5A5A, 1'b0, rd, er, n0, n1, da, dw, lat);
      e = sb.pop_front();
      vectors++;
      if ({rd, er} !== {e.rdata, e.err}) begin miscompares++; $display("FAIL decode_err_store[%h] got %h/%b exp %h/%b", addrs[i], rd, er, e.rdata, e.err); end
      vectors++;
      if (n0 + n1 !== 0) begin miscompares++; $display("FAIL decode_err_strobes[%h] got %0d exp 0", addrs[i], n0 + n1); end
    end
  endtask

  task automatic test_timer_irq();
    @(negedge clk);
    tc0_irq = 1'b1; tc1_irq = 1'b1;
    @(negedge clk);
    vectors++;
    if (hwint !== 6'b000011) begin miscompares++; $display("FAIL timer_irq_on got %b exp 000011", hwint); end
    tc0_irq = 1'b0; tc1_irq = 1'b0;
    @(negedge clk);
    vectors++;
    if (hwint !== 6'b000000) begin miscompares++; $display("FAIL timer_irq_off got %b exp 000000", hwint); end
  endtask

  task automatic test_ext_irq();
    logic [31:0] rd; logic er; int n0, n1, lat; logic [29:0] da; logic [31:0] dw; exp_t e;
    @(negedge clk);
    ext_irq = 1'b1;
    @(negedge clk);
    vectors++;
    if (hwint[2] !== 1'b0) begin miscompares++; $display("FAIL ext_lag1 got %b exp 0", hwint[2]); end
    @(negedge clk);
    vectors++;
    if (hwint[2] !== 1'b1) begin miscompares++; $display("FAIL ext_lag2 got %b exp 1", hwint[2]); end
    repeat (3) @(negedge clk);
    ext_irq = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (hwint !== 6'b000100) begin miscompares++; $display("FAIL ext_held got %b exp 000100", hwint); end
    sb.push_back('{rdata: 32'd1, err: 1'b0});
    run_access(1'b0, 32'h0000_7F20, 32'h0, 1'b0, rd, er, n0, n1, da, dw, lat);
    e = sb.pop_front();
    vectors++;
    if ({rd, er} !== {e.rdata, e.err}) begin miscompares++; $display("FAIL ext_load_pending got %h/%b exp %h/%b", rd, er, e.rdata, e.err); end
    sb.push_back('{rdata: 32'd0, err: 1'b0});
    run_access(1'b1, 32'h0000_7F20, 32'hFFFF_FFFF, 1'b0, rd, er, n0, n1, da, dw, lat);
    e = sb.pop_front();
    vectors++;
    if ({rd, er} !== {e.rdata, e.err}) begin miscompares++; $display("FAIL ext_store_resp got %h/%b exp %h/%b", rd, er, e.rdata, e.err); end
    vectors++;
    if (n0 + n1 !== 0) begin miscompares++; $display("FAIL ext_store_strobes got %0d exp 0", n0 + n1); end
    vectors++;
    if (hwint[2] !== 1'b1) begin miscompares++; $display("FAIL ext_clear_lag got %b exp 1", hwint[2]); end
    @(negedge clk);
    vectors++;
    if (hwint[2] !== 1'b0) begin miscompares++; $display("FAIL ext_cleared got %b exp 0", hwint[2]); end
    // edge arriving in the clear cycle must survive
    sb.push_back('{rdata: 32'd0, err: 1'b0});
    run_access(1'b1, 32'h0000_7F20, 32'h0, 1'b1, rd, er, n0, n1, da, dw, lat);
    e = sb.pop_front();
    vectors++;
    if ({rd, er} !== {e.rdata, e.err}) begin miscompares++; $display("FAIL ext_race_store got %h/%b exp %h/%b", rd, er, e.rdata, e.err); end
    ext_irq = 1'b0;
    sb.push_back('{rdata: 32'd1, err: 1'b0});
    run_access(1'b0, 32'h0000_7F20, 32'h0, 1'b0, rd, er, n0, n1, da, dw, lat);
    e = sb.pop_front();
    vectors++;
    if ({rd, er} !== {e.rdata, e.err}) begin miscompares++; $display("FAIL ext_set_wins got %h/%b exp %h/%b", rd, er, e.rdata, e.err); end
    sb.push_back('{rdata: 32'd0, err: 1'b0});
    run_access(1'b1, 32'h0000_7F20, 32'h0, 1'b0, rd, er, n0, n1, da, dw, lat);
    e = sb.pop_front();
    @(negedge clk);
    vectors++;
    if (hwint !== 6'd0) begin miscompares++; $display("FAIL ext_final_clear got %b exp 000000", hwint); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int n0, n1, lat; logic [29:0] da; logic [31:0] dw; exp_t e;
    int seen_rvalid = 0;
    int guard = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_7F04; cpu_wdata = 32'h77;
    while (!cpu_ready && guard < 20) begin guard++; @(negedge clk); end
    @(negedge clk);
    cpu_req = 1'b0;
    vectors++;
    if (tc0_we !== 1'b1) begin miscompares++; $display("FAIL abort_strobe_before got %b exp 1", tc0_we); end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({tc0_we, cpu_rvalid, cpu_ready} !== 3'b000) begin
      miscompares++; $display("FAIL abort_drop got %b exp 000", {tc0_we, cpu_rvalid, cpu_ready});
    end
    repeat (2) begin
      @(negedge clk);
      seen_rvalid += int'(cpu_rvalid);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got %b exp 1", cpu_ready); end
    repeat (3) begin
      seen_rvalid += int'(cpu_rvalid);
      @(negedge clk);
    end
    vectors++;
    if (seen_rvalid !== 0) begin miscompares++; $display("FAIL abort_no_resp got %0d exp 0", seen_rvalid); end
    tc1_rdata = 32'hCAFE_0001;
    sb.push_back('{rdata: 32'hCAFE_0001, err: 1'b0});
    run_access(1'b0, 32'h0000_7F14, 32'h0, 1'b0, rd, er, n0, n1, da, dw, lat);
    e = sb.pop_front();
    vectors++;
    if ({rd, er} !== {e.rdata, e.err}) begin miscompares++; $display("FAIL abort_followup got %h/%b exp %h/%b", rd, er, e.rdata, e.err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int n0, n1, lat; logic [29:0] da; logic [31:0] dw; exp_t e;
    for (int i = 0; i < 3; i++) sb.push_back('{rdata: 32'hA000_0000 | 32'(i), err: 1'b0});
    for (int i = 0; i < 3; i++) begin
      tc0_rdata = 32'hA000_0000 | 32'(i);
      run_access(1'b0, 32'h0000_7F00 + 32'(4 * i), 32'h0, 1'b0, rd, er, n0, n1, da, dw, lat);
      e = sb.pop_front();
      vectors++;
      if ({rd, er} !== {e.rdata, e.err}) begin miscompares++; $display("FAIL b2b_load[%0d] got %h/%b exp %h/%b", i, rd, er, e.rdata, e.err); end
    end
    sb.push_back('{rdata: 32'd0, err: 1'b0});
    run_access(1'b1, 32'h0000_7F18, 32'h0000_1234, 1'b0, rd, er, n0, n1, da, dw, lat);
    e = sb.pop_front();
    vectors++;
    if ({rd, er, n0, n1, da, dw} !== {e.rdata, e.err, 32'd0, 32'd1, 30'h1FC6, 32'h1234}) begin
      miscompares++; $display("FAIL b2b_store_tc1 got %h/%b %0d/%0d %h %h exp 0/0 0/1 1fc6 1234", rd, er, n0, n1, da, dw);
    end
  endtask

  initial begin
    test_reset();
    test_store_tc0();
    test_load_tc1();
    test_decode_errors();
    test_timer_irq();
    test_ext_irq();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
